fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the write side of one `async_fifo` instance between `N_REQ` requesters in the write-clock domain. It grants one requester at a time for a burst of up to `MAX_BURST` beats, drives the FIFO `wr_en`/`wr_data`, and respects `full`/`almost_full` backpressure. It sits between the producer blocks and the FIFO write port.

---
 rtl/fifo_wr_arbiter_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-port arbiter.
//   state_e       - FSM encoding (IDLE / BURST)
//   DEF_*         - default parameter values
//   clog2()       - index width helper, usable in parameter expressions
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bus plus FIFO write port of the arbiter.
//   req/last/data      - per-requester request, end-of-burst flag, data
//   fifo_full/almost   - FIFO backpressure
//   gnt/owner/busy     - grant state (registered)
//   fifo_wr_en/wr_data - FIFO write strobe and data
// modport master: the arbiter. modport slave: producers + FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IW    = clog2(N_REQ)
) ();

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            last;
  logic [N_REQ-1:0][WIDTH-1:0] data;
  logic                        fifo_full;
  logic                        fifo_almost_full;
  logic [N_REQ-1:0]            gnt;
  logic [IW-1:0]               owner;
  logic                        busy;
  logic                        fifo_wr_en;
  logic [WIDTH-1:0]            fifo_wr_data;

  modport master (
    input  req, last, data, fifo_full, fifo_almost_full,
    output gnt, owner, busy, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req, last, data, fifo_full, fifo_almost_full,
    input  gnt, owner, busy, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req        - request vector
//   last_owner - previous winner; search starts at last_owner+1 (mod N_REQ)
//   valid      - some request is set
//   winner     - index of the first set request in rotated order
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             valid,
  output logic [IW-1:0]    winner
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_owner) + i) % N_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ requesters, with bursts of up to MAX_BURST beats per grant.
//   clk   - write-side clock
//   rst_n - synchronous active-low reset
//   bus   - fifo_wr_arbiter_if.master (requests, backpressure, grant, write)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic                clk,
  input logic                rst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IW = clog2(N_REQ);
  localparam int BW = clog2(MAX_BURST) + 1;

  state_e           state;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last_owner;
  logic [BW-1:0]    beat_cnt;
  logic             busy_q;

  logic             accept;
  logic             release_b;
  logic [N_REQ-1:0] pick_req;
  logic [IW-1:0]    pick_ptr;
  logic             pick_valid;
  logic [IW-1:0]    pick_winner;
  logic [N_REQ-1:0] pick_oh;
  logic             grant_ok;
  logic [WIDTH-1:0] wr_data;

  assign accept = (state == BURST) && bus.req[owner] && !bus.fifo_full;

  // Release on the final accepted beat (last or cap), or when the owner
  // withdraws its request (no beat written that cycle).
  assign release_b = (state == BURST) &&
                     ((accept && (bus.last[owner] ||
                                  beat_cnt == BW'(MAX_BURST - 1))) ||
                      !bus.req[owner]);

  // A beat flagged last completes the owner's transaction, so its still-high
  // req that cycle belongs to the finished burst and must not re-win. A cap
  // release leaves the owner eligible (it may be the only requester).
  assign pick_req = bus.req & ~((accept && bus.last[owner]) ? gnt_q : '0);

  // Re-arbitration at release searches from the current owner, which is the
  // value last_owner takes on that same edge.
  assign pick_ptr = (state == BURST) ? owner : last_owner;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (pick_req),
    .last_owner (pick_ptr),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_winner;
  assign grant_ok = pick_valid && !bus.fifo_almost_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= '0;
      owner      <= '0;
      busy_q     <= 1'b0;
      beat_cnt   <= '0;
      last_owner <= IW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state    <= BURST;
            busy_q   <= 1'b1;
            owner    <= pick_winner;
            gnt_q    <= pick_oh;
            beat_cnt <= '0;
          end else begin
            gnt_q <= '0;
          end
        end
        BURST: begin
          if (release_b) begin
            last_owner <= owner;
            beat_cnt   <= '0;
            if (grant_ok) begin
              owner <= pick_winner;
              gnt_q <= pick_oh;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              gnt_q  <= '0;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          gnt_q  <= '0;
        end
      endcase
    end
  end

  assign wr_data = bus.data[owner];

  assign bus.gnt          = gnt_q;
  assign bus.owner        = owner;
  assign bus.busy         = busy_q;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus a burst-alternation sequence.
// Inputs are driven on the falling edge; all outputs are sampled 1 time unit
// later, so registered outputs show the current state and wr_en/wr_data show
// the combinational response to the row's inputs.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lst;
    logic [7:0] d2;
    logic       full;
    logic       af;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
    logic       wen;
    logic [7:0] wd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int row,
                     input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                       input logic [7:0] d2, input logic f, input logic a);
    rst_n                = r;
    bus.req              = rq;
    bus.last             = ls;
    bus.data             = {8'h43, d2, 8'h21, 8'h10};
    bus.fifo_full        = f;
    bus.fifo_almost_full = a;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    //          rst   req      last     d2     full  af    gnt      own    busy  wen   wd
    // reset held with all requesting, then release: requester 0 first
    vq.push_back('{1'b0, 4'b1111, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h10});
    vq.push_back('{1'b1, 4'b1111, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h10});
    // burst cap: 4 beats req0, 4 beats req1, back to req0, no gaps
    for (int i = 0; i < 4; i++)
      vq.push_back('{1'b1, 4'b0011, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h10});
    for (int i = 0; i < 4; i++)
      vq.push_back('{1'b1, 4'b0011, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h21});
    // owner 0 withdraws: no write, back to idle
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h10});
    // early last: requester 2 writes A1, A2 then grant drops
    vq.push_back('{1'b1, 4'b0100, 4'b0000, 8'hA1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h10});
    vq.push_back('{1'b1, 4'b0100, 4'b0000, 8'hA1, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA1});
    vq.push_back('{1'b1, 4'b0100, 4'b0100, 8'hA2, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h32});
    // full stall: beat 1, 3 stalled cycles, beats 2..4
    vq.push_back('{1'b1, 4'b0010, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 8'h32});
    vq.push_back('{1'b1, 4'b0010, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h21});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1'b1, 4'b0010, 4'b0000, 8'h32, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h21});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1'b1, 4'b0010, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h21});
    // sole requester re-granted at cap release, then withdraws
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h21});
    // almost_full blocks a new grant; once clear, grant one cycle later
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h21});
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h21});
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 8'h21});
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h43});
    // almost_full mid-burst does not stop writes
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h43});
    vq.push_back('{1'b1, 4'b1000, 4'b1000, 8'h32, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h43});
    // abandon: owner 0 drops after 1 beat, requester 3 granted next cycle
    vq.push_back('{1'b1, 4'b1001, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h43});
    vq.push_back('{1'b1, 4'b1001, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 8'h10});
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h10});
    vq.push_back('{1'b1, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h43});
    // reset mid-burst forces idle and rewinds the pointer
    vq.push_back('{1'b0, 4'b1000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h43});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h10});
    vq.push_back('{1'b1, 4'b0110, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h10});
    vq.push_back('{1'b1, 4'b0110, 4'b0000, 8'h32, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h21});

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].rst_n, vq[k].req, vq[k].lst, vq[k].d2, vq[k].full, vq[k].af);
      #1;
      chk("gnt",     k, {4'b0, bus.gnt},      {4'b0, vq[k].gnt});
      chk("owner",   k, {6'b0, bus.owner},    {6'b0, vq[k].own});
      chk("busy",    k, {7'b0, bus.busy},     {7'b0, vq[k].busy});
      chk("wr_en",   k, {7'b0, bus.fifo_wr_en}, {7'b0, vq[k].wen});
      chk("wr_data", k, bus.fifo_wr_data,     vq[k].wd);
    end

    // Sustained alternation: two requesters held for 16 beats after one
    // idle grant cycle; owner flips every MAX_BURST beats, never a gap.
    begin
      int writes;
      logic [1:0] eo;
      writes = 0;
      @(negedge clk);
      drive(1'b0, 4'b0000, 4'b0000, 8'h32, 1'b0, 1'b0);
      for (int c = 0; c <= 16; c++) begin
        @(negedge clk);
        drive(1'b1, 4'b0011, 4'b0000, 8'h32, 1'b0, 1'b0);
        #1;
        if (bus.fifo_wr_en) writes++;
        if (c == 0) begin
          chk("alt_idle_wen", c, {7'b0, bus.fifo_wr_en}, 8'h00);
        end else begin
          eo = 2'(((c - 1) / 4) % 2);
          chk("alt_wen",   c, {7'b0, bus.fifo_wr_en}, 8'h01);
          chk("alt_owner", c, {6'b0, bus.owner}, {6'b0, eo});
          chk("alt_data",  c, bus.fifo_wr_data, (eo == 2'd0) ? 8'h10 : 8'h21);
        end
      end
      chk("alt_writes", 0, 8'(writes), 8'd16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
